rx_frame_ctrl: RTL and testbench

// Receive-side frame sequencer placed after the symbol decision stage.

---
 rtl/rx_frame_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// rx_frame_ctrl
//   Receive-side frame sequencer after the symbol decision stage. It hunts
//   for a 16-bit sync word, reads a length byte and assembles payload bits
//   into bytes, which are handed to a sink over a valid/ready stream.
//   Frame start, frame end and frame abort (with cause) are reported as
//   single-cycle pulses.
//
// Ports
//   clk, rst      system clock; asynchronous active-high reset
//   sym_valid     one-cycle strobe per decided symbol
//   sym_code      00 no carrier, 01 bit 1, 10 bit 0, 11 invalid
//   byte_data     payload byte, MSB is the first received bit
//   byte_valid    byte_data valid, held until accepted
//   byte_ready    sink ready
//   frame_start   pulse: sync word matched
//   frame_end     pulse: last payload byte accepted by the sink
//   frame_err     pulse: frame aborted
//   err_code      abort cause with frame_err: 01 bad len, 10 carrier lost,
//                 11 overflow / invalid symbol (00 otherwise)
//   busy          high while reading the length or the payload
//
// Stream handshake: a byte transfers on every rising clk edge where
// byte_valid && byte_ready. Once raised, byte_valid and byte_data stay
// stable until that transfer, unless the frame aborts (byte_valid drops).
// ---------------------------------------------------------------------------
module rx_frame_ctrl #(
    parameter logic [15:0] SYNC_WORD  = 16'hA5C3,
    parameter int          MAX_LEN    = 64,
    parameter int          ZERO_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sym_valid,
    input  logic [1:0] sym_code,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] MAX_LEN_B    = 8'(MAX_LEN);
    localparam logic [7:0] ZERO_LIMIT_B = 8'(ZERO_LIMIT);

    state_t      state_q, state_d;
    logic [15:0] sync_q, sync_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  zero_cnt_q, zero_cnt_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        byte_valid_q, byte_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_end_q, frame_end_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic        accept;
    logic        is_data;
    logic        data_bit;
    logic [7:0]  shift_nxt;
    logic [15:0] sync_nxt;
    logic [7:0]  zero_inc;
    logic        abort;
    logic [1:0]  abort_code;

    assign accept    = byte_valid_q && byte_ready;
    assign is_data   = sym_code[1] ^ sym_code[0];
    assign data_bit  = (sym_code == 2'b01);
    assign shift_nxt = {shift_q[6:0], data_bit};
    assign sync_nxt  = {sync_q[14:0], data_bit};
    assign zero_inc  = (zero_cnt_q == 8'hFF) ? 8'hFF : zero_cnt_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        sync_d        = sync_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        len_d         = len_q;
        byte_cnt_d    = byte_cnt_q;
        zero_cnt_d    = zero_cnt_q;
        byte_data_d   = byte_data_q;
        byte_valid_d  = byte_valid_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = 2'b00;
        abort         = 1'b0;
        abort_code    = 2'b00;

        if (accept) begin
            byte_valid_d = 1'b0;
        end

        case (state_q)
            ST_HUNT: begin
                if (sym_valid) begin
                    if (is_data) begin
                        if (sync_nxt == SYNC_WORD) begin
                            frame_start_d = 1'b1;
                            state_d       = ST_LEN;
                            sync_d        = '0;
                            shift_d       = '0;
                            bit_cnt_d     = '0;
                            byte_cnt_d    = '0;
                            zero_cnt_d    = '0;
                        end else begin
                            sync_d = sync_nxt;
                        end
                    end else begin
                        sync_d = '0;
                    end
                end
            end

            ST_LEN, ST_PAYLOAD: begin
                if (sym_valid) begin
                    if (sym_code == 2'b11) begin
                        abort      = 1'b1;
                        abort_code = 2'b11;
                    end else if (sym_code == 2'b00) begin
                        zero_cnt_d = zero_inc;
                        if (zero_inc >= ZERO_LIMIT_B) begin
                            abort      = 1'b1;
                            abort_code = 2'b10;
                        end
                    end else begin
                        zero_cnt_d = '0;
                        shift_d    = shift_nxt;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ST_LEN) begin
                                if (shift_nxt == 8'd0 || shift_nxt > MAX_LEN_B) begin
                                    abort      = 1'b1;
                                    abort_code = 2'b01;
                                end else begin
                                    len_d   = shift_nxt;
                                    state_d = ST_PAYLOAD;
                                end
                            end else if (byte_valid_q && !byte_ready) begin
                                // previous byte still pending: the new one has nowhere to go
                                abort      = 1'b1;
                                abort_code = 2'b11;
                            end else begin
                                byte_data_d  = shift_nxt;
                                byte_valid_d = 1'b1;
                                byte_cnt_d   = byte_cnt_q + 8'd1;
                                if (byte_cnt_q + 8'd1 == len_q) begin
                                    state_d = ST_DONE;
                                end
                            end
                        end
                    end
                end
            end

            ST_DONE: begin
                // symbols are ignored here; only the final accept matters
                if (accept) begin
                    frame_end_d = 1'b1;
                    state_d     = ST_HUNT;
                    sync_d      = '0;
                    bit_cnt_d   = '0;
                    byte_cnt_d  = '0;
                    zero_cnt_d  = '0;
                end
            end

            default: state_d = ST_HUNT;
        endcase

        if (abort) begin
            frame_err_d  = 1'b1;
            err_code_d   = abort_code;
            state_d      = ST_HUNT;
            byte_valid_d = 1'b0;
            sync_d       = '0;
            bit_cnt_d    = '0;
            byte_cnt_d   = '0;
            zero_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            sync_q        <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            len_q         <= '0;
            byte_cnt_q    <= '0;
            zero_cnt_q    <= '0;
            byte_data_q   <= '0;
            byte_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= 2'b00;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            len_q         <= len_d;
            byte_cnt_q    <= byte_cnt_d;
            zero_cnt_q    <= zero_cnt_d;
            byte_data_q   <= byte_data_d;
            byte_valid_q  <= byte_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign byte_data   = byte_data_q;
    assign byte_valid  = byte_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign busy        = (state_q == ST_LEN) || (state_q == ST_PAYLOAD);

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_ctrl
//   Directed scenarios followed by randomized frames. Expected bytes,
//   frame start/end counts and error codes come from a frame-level model
//   (length rule, payload list); a monitor collects what the DUT delivers.
// ---------------------------------------------------------------------------
module tb_rx_frame_ctrl;
    localparam logic [15:0] SYNC       = 16'hA5C3;
    localparam int          MAX_LEN    = 64;
    localparam int          ZERO_LIMIT = 8;

    // clock / reset / DUT
    logic       clk = 1'b0;
    logic       rst;
    logic       sym_valid;
    logic [1:0] sym_code;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_start;
    logic       frame_end;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    always #5 clk = ~clk;

    rx_frame_ctrl #(.SYNC_WORD(SYNC), .MAX_LEN(MAX_LEN), .ZERO_LIMIT(ZERO_LIMIT)) dut (
        .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_code(sym_code),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .frame_start(frame_start), .frame_end(frame_end), .frame_err(frame_err),
        .err_code(err_code), .busy(busy)
    );

    // scoreboard state
    int         tests = 0;
    int         fails = 0;
    int         n_start = 0, n_end = 0;
    int         exp_start = 0, exp_end = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [1:0] err_q[$];
    logic [1:0] exp_err_q[$];
    logic [7:0] pl[256];
    int         gap_max = 0;
    bit         zero_inj = 0;

    // monitor: pre-edge values of the DUT outputs
    always @(posedge clk) begin
        if (!rst) begin
            if (byte_valid && byte_ready) got_q.push_back(byte_data);
            if (frame_start) n_start++;
            if (frame_end) n_end++;
            if (frame_err) err_q.push_back(err_code);
        end
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic [1:0] code);
        sym_valid = 1'b1;
        sym_code  = code;
        step();
        sym_valid = 1'b0;
        sym_code  = 2'b00;
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, gap_max);
        repeat (n) step();
    endtask

    task automatic send_bit(input logic b);
        if (zero_inj && $urandom_range(0, 15) == 0) begin
            int nz;
            nz = $urandom_range(1, 3);
            repeat (nz) begin
                sym(2'b00);
                gap();
            end
        end
        sym(b ? 2'b01 : 2'b10);
        gap();
    endtask

    task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 7, 0);
    endtask

    task automatic send_sync();
        send_byte(SYNC[15:8]);
        send_byte(SYNC[7:0]);
    endtask

    // frame-level model: a good length yields its payload and one frame end,
    // a bad length yields a single err 01
    task automatic expect_frame(input int len);
        exp_start++;
        if (len == 0 || len > MAX_LEN) begin
            exp_err_q.push_back(2'b01);
        end else begin
            for (int i = 0; i < len; i++) exp_q.push_back(pl[i]);
            exp_end++;
        end
    endtask

    task automatic fill_payload(input int len);
        for (int i = 0; i < len; i++) pl[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_frame(input string tag);
        repeat (4) step();
        chk({tag, ":starts"}, n_start, exp_start);
        chk({tag, ":ends"}, n_end, exp_end);
        chk({tag, ":nbytes"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, ":byte"}, got_q.pop_front(), exp_q.pop_front());
        chk({tag, ":nerrs"}, err_q.size(), exp_err_q.size());
        while (err_q.size() > 0 && exp_err_q.size() > 0)
            chk({tag, ":errcode"}, err_q.pop_front(), exp_err_q.pop_front());
        got_q.delete();
        exp_q.delete();
        err_q.delete();
        exp_err_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, ":byte_data"}, byte_data, 8'h00);
        chk({tag, ":byte_valid"}, byte_valid, 1'b0);
        chk({tag, ":frame_start"}, frame_start, 1'b0);
        chk({tag, ":frame_end"}, frame_end, 1'b0);
        chk({tag, ":frame_err"}, frame_err, 1'b0);
        chk({tag, ":err_code"}, err_code, 2'b00);
        chk({tag, ":busy"}, busy, 1'b0);
    endtask

    task automatic clean_frame(input string tag, input int len);
        fill_payload(len);
        send_sync();
        send_byte(8'(len));
        for (int i = 0; i < len; i++) send_byte(pl[i]);
        expect_frame(len);
        check_frame(tag);
    endtask

    initial begin
        int len;
        int sel;
        int noise;

        // reset
        rst        = 1'b1;
        sym_valid  = 1'b0;
        sym_code   = 2'b00;
        byte_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check_idle_outputs("reset");

        // spec frame with cycle-exact checks
        gap_max = 0;
        pl[0] = 8'h3C;
        pl[1] = 8'h81;
        send_sync();
        chk("spec:start_pulse", frame_start, 1'b1);
        chk("spec:busy_len", busy, 1'b1);
        send_byte(8'd2);
        chk("spec:start_one_clk", frame_start, 1'b0);
        send_bits(8'h3C, 7, 1);
        chk("spec:valid_before_bit8", byte_valid, 1'b0);
        send_bit(1'b0);
        chk("spec:valid_after_bit8", byte_valid, 1'b1);
        chk("spec:data_3c", byte_data, 8'h3C);
        send_byte(8'h81);
        chk("spec:valid_last", byte_valid, 1'b1);
        step();
        chk("spec:end_pulse", frame_end, 1'b1);
        chk("spec:busy_after", busy, 1'b0);
        step();
        chk("spec:end_one_clk", frame_end, 1'b0);
        expect_frame(2);
        check_frame("spec");

        // bad lengths, then re-arm
        send_sync();
        send_byte(8'd0);
        chk("len0:err", frame_err, 1'b1);
        chk("len0:code", err_code, 2'b01);
        chk("len0:busy", busy, 1'b0);
        expect_frame(0);
        check_frame("len0");
        send_sync();
        send_byte(8'd65);
        chk("len65:err", frame_err, 1'b1);
        chk("len65:code", err_code, 2'b01);
        expect_frame(65);
        check_frame("len65");
        clean_frame("rearm", 1);

        // carrier loss after ZERO_LIMIT zeros
        fill_payload(3);
        send_sync();
        send_byte(8'd3);
        send_byte(pl[0]);
        repeat (ZERO_LIMIT - 1) sym(2'b00);
        chk("zero7:no_err", frame_err, 1'b0);
        chk("zero7:busy", busy, 1'b1);
        sym(2'b00);
        chk("zero8:err", frame_err, 1'b1);
        chk("zero8:code", err_code, 2'b10);
        exp_start++;
        exp_q.push_back(pl[0]);
        exp_err_q.push_back(2'b10);
        check_frame("zero8");

        // one zero short of the limit, then the frame resumes
        fill_payload(3);
        send_sync();
        send_byte(8'd3);
        send_byte(pl[0]);
        repeat (ZERO_LIMIT - 1) sym(2'b00);
        send_byte(pl[1]);
        send_byte(pl[2]);
        expect_frame(3);
        check_frame("zero7");

        // overflow: sink never ready
        fill_payload(2);
        byte_ready = 1'b0;
        send_sync();
        send_byte(8'd2);
        send_byte(pl[0]);
        send_byte(pl[1]);
        chk("ovf:err", frame_err, 1'b1);
        chk("ovf:code", err_code, 2'b11);
        chk("ovf:valid_dropped", byte_valid, 1'b0);
        byte_ready = 1'b1;
        exp_start++;
        exp_err_q.push_back(2'b11);
        check_frame("ovf");

        // ready arrives in the clk the second byte completes
        fill_payload(2);
        byte_ready = 1'b0;
        send_sync();
        send_byte(8'd2);
        send_byte(pl[0]);
        send_bits(pl[1], 7, 1);
        byte_ready = 1'b1;
        send_bit(pl[1][0]);
        chk("same_clk:no_err", frame_err, 1'b0);
        chk("same_clk:valid", byte_valid, 1'b1);
        chk("same_clk:data", byte_data, pl[1]);
        expect_frame(2);
        check_frame("same_clk");

        // invalid symbol inside the sync pattern: no frame
        send_byte(SYNC[15:8]);
        send_bits(SYNC[7:0], 7, 4);
        sym(2'b11);
        send_bits(SYNC[7:0], 3, 0);
        chk("sync11:no_start", frame_start, 1'b0);
        chk("sync11:busy", busy, 1'b0);
        check_frame("sync11");

        // invalid symbol in payload
        fill_payload(4);
        send_sync();
        send_byte(8'd4);
        send_byte(pl[0]);
        send_bits(pl[1], 7, 5);
        sym(2'b11);
        chk("pay11:err", frame_err, 1'b1);
        chk("pay11:code", err_code, 2'b11);
        exp_start++;
        exp_q.push_back(pl[0]);
        exp_err_q.push_back(2'b11);
        check_frame("pay11");

        // reset during payload with a byte pending
        fill_payload(2);
        byte_ready = 1'b0;
        send_sync();
        send_byte(8'd2);
        send_byte(pl[0]);
        chk("rst_mid:valid_before", byte_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid:valid", byte_valid, 1'b0);
        chk("rst_mid:data", byte_data, 8'h00);
        chk("rst_mid:busy", busy, 1'b0);
        chk("rst_mid:err", frame_err, 1'b0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        byte_ready = 1'b1;
        step();
        exp_start++;
        check_frame("rst_mid");
        clean_frame("post_rst", 2);

        // randomized frames: HUNT noise, random gaps, stray zeros, lengths
        gap_max = 2;
        for (int f = 0; f < 25; f++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      len = 0;
            else if (sel == 1) len = $urandom_range(MAX_LEN + 1, 255);
            else if (sel == 2) len = MAX_LEN;
            else               len = $urandom_range(1, 12);
            noise = $urandom_range(0, 12);
            for (int i = 0; i < noise; i++) send_bit(1'($urandom_range(0, 1)));
            sym(2'b00);
            fill_payload((len > MAX_LEN) ? 0 : len);
            send_sync();
            send_byte(8'(len));
            if (len != 0 && len <= MAX_LEN) begin
                zero_inj = 1;
                for (int i = 0; i < len; i++) send_byte(pl[i]);
                zero_inj = 0;
            end
            expect_frame(len);
            check_frame($sformatf("rand%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
